char_ram_arbiter: RTL and testbench
===================================

CHAR_RAM_ARBITER -- requirements
Module: char_ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: ADDR_W, 13, character RAM address width.
REQ-002 DATA_W, 7, character code width.
REQ-003 RAM_DEPTH, 4800, number of character cells (80x60).
REQ-004 CLEAR_CHAR, 7'h20, code written during a clear sweep.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 clear_start  input  1  single-cycle request to sweep the whole RAM with CLEAR_CHAR.
REQ-008 req  input  3  per-requester write request; bit i belongs to requester i.
REQ-009 req_addr  input  3*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
REQ-010 req_data  input  3*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
REQ-011 ack  output  3  one-hot, single-cycle; requester i write committed this cycle.
REQ-012 clear_busy  output  1  high for the whole clear sweep.
REQ-013 clear_done  output  1  single-cycle pulse after the final clear write.
REQ-014 ram_wr_en  output  1  write enable to character RAM port A.
REQ-015 ram_addr  output  ADDR_W  write address to port A.
REQ-016 ram_data  output  DATA_W  write data to port A.

Function
REQ-017 All outputs SHALL be registered; at most one RAM write SHALL occur per cycle.
REQ-018 States SHALL be IDLE and CLEAR; reset enters IDLE.
REQ-019 IDLE: when any eligible req bit is sampled high at edge N, the winner's addr/data SHALL appear on ram_addr/ram_data with ram_wr_en=1 and ack[winner]=1 during cycle N+1 (latency 1).
REQ-020 Eligible = req[i] high AND ack[i] currently low; a requester SHALL NOT be granted in the cycle its ack is asserted (no double write while requester updates).
REQ-021 Requester SHALL hold req/addr/data stable until ack; may reassert for next write the cycle after ack.
REQ-022 Arbitration SHALL be round-robin: pointer starts at 0; search order ptr, ptr+1, ptr+2 (mod 3); after granting i, ptr = (i+1) mod 3; ptr unchanged when nothing granted.
REQ-023 No eligible request: ram_wr_en=0, ack=0; ram_addr/ram_data hold last values.
REQ-024 IDLE with clear_start sampled high: SHALL enter CLEAR next cycle, clear_start taking priority over any simultaneous req (no grant that cycle).
REQ-025 CLEAR: counter 0..RAM_DEPTH-1, one write per cycle, ram_wr_en=1, ram_data=CLEAR_CHAR, ram_addr=counter; clear_busy=1 in every such cycle; ack=0 throughout.
REQ-026 Write with ram_addr=RAM_DEPTH-1 SHALL be the last; next cycle: clear_busy=0, clear_done=1, ram_wr_en=0, state IDLE, arbitration resumes with the following edge.
REQ-027 clear_start while in CLEAR SHALL be ignored (no restart, no extension).
REQ-028 Pending requests during CLEAR SHALL stay pending and be served by round-robin after CLEAR (pointer unchanged by CLEAR).
REQ-029 Counter SHALL be ceil(log2(RAM_DEPTH)) bits; no write SHALL target an address >= RAM_DEPTH.

Reset
REQ-030 rst high at an edge SHALL, next cycle: state IDLE, ptr=0, counter=0, ack=0, ram_wr_en=0, ram_addr=0, ram_data=0, clear_busy=0, clear_done=0.
REQ-031 rst mid-CLEAR SHALL abort the sweep with no clear_done pulse; rst SHALL override clear_start and req in the same cycle.

Verification
REQ-032 Single: req=3'b010, addr1=13'd100, data1=7'h41 for one sample -> next cycle ram_wr_en=1, ram_addr=100, ram_data=7'h41, ack=3'b010; no second write while req held until ack.
REQ-033 Round-robin: req=3'b111 held, each dropping after its ack -> grant order 0,1,2, back-to-back writes on three consecutive cycles.
REQ-034 Fairness: req0 and req2 continuously reasserted after each ack -> grants alternate 0,2,0,2; neither starved.
REQ-035 Clear: clear_start with req=3'b001 same cycle -> 4800 writes of 7'h20 at addresses 0..4799, clear_busy high 4800 cycles, ack0 only after clear_done pulse.
REQ-036 Reset mid-clear: rst at counter=2000 -> next cycle all outputs 0, state IDLE, no clear_done; fresh clear_start restarts at address 0.
REQ-037 Ignore: clear_start pulsed at counter=10 during CLEAR -> sweep ends at 4799 with exactly one clear_done.

Source files
------------

// File: rtl/char_ram_arbiter.sv
// Character RAM write-port arbiter: three round-robin requesters plus a
// full-screen clear sweep that writes CLEAR_CHAR into every cell.
module char_ram_arbiter #(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 7,
  parameter int                RAM_DEPTH  = 4800,
  parameter logic [DATA_W-1:0] CLEAR_CHAR = 7'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_start,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            ack,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  ram_wr_en,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_data
);

  localparam int CNT_W = $clog2(RAM_DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RAM_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q;
  logic [1:0]          ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          ack_q;
  logic                wr_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic [2:0]          elig;
  logic [1:0]          p1;
  logic [1:0]          p2;
  logic [1:0]          win;
  logic                any;
  logic [1:0]          ptr_d;
  logic [2:0]          ack_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A requester whose ack is showing is masked so it cannot be granted twice
  always_comb begin
    elig = req & ~ack_q;
    p1   = inc3(ptr_q);
    p2   = inc3(p1);
    any  = |elig;
    win  = ptr_q;
    if (elig[p2])    win = p2;
    if (elig[p1])    win = p1;
    if (elig[ptr_q]) win = ptr_q;
    ptr_d  = inc3(win);
    ack_d  = any ? (3'b001 << win) : 3'b000;
    addr_d = req_addr[win*ADDR_W +: ADDR_W];
    data_d = req_data[win*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      ack_q   <= 3'b000;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= CLEAR_CHAR;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
            ack_q   <= 3'b000;
          end else begin
            ack_q <= ack_d;
            wr_q  <= any;
            if (any) begin
              ptr_q  <= ptr_d;
              addr_q <= addr_d;
              data_q <= data_d;
            end
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= ADDR_W'(cnt_q + 1'b1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign ram_wr_en  = wr_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Scoreboard bench for char_ram_arbiter: every expected RAM write is queued
// when stimulus is driven and compared when the DUT writes.
module tb_char_ram_arbiter;
  localparam int AW = 13;
  localparam int DW = 7;
  localparam int DEPTH = 4800;
  localparam logic [DW-1:0] CC = 7'h20;

  logic clk = 1'b0;
  logic rst;
  logic clear_start;
  logic [2:0] req;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0] ack;
  logic clear_busy;
  logic clear_done;
  logic ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    k;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int n_pass = 0;
  int n_total = 0;

  char_ram_arbiter dut (
    .clk(clk), .rst(rst), .clear_start(clear_start),
    .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_wr_en === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: got addr=%0d data=%h ack=%b, required no write",
                 ram_addr, ram_data, ack);
      end else begin
        e = exp_q.pop_front();
        if ({ram_addr, ram_data, ack} !== e)
          $display("FAIL wr_content: got addr=%0d data=%h ack=%b, required addr=%0d data=%h ack=%b",
                   ram_addr, ram_data, ack, e.a, e.d, e.k);
        else n_pass++;
      end
    end
  end

  function automatic wr_t mk(input int a, input int d, input logic [2:0] k);
    return {AW'(a), DW'(d), k};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
    req[i] = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_start = 1'b0;
    req = 3'b000;
    tick;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_clear(input int pulse_at, output int busy_n,
                           output int done_n, output int ack_n);
    busy_n = 0;
    done_n = 0;
    ack_n = 0;
    for (int c = 0; c < 6000 && done_n == 0; c++) begin
      if (clear_busy === 1'b1) busy_n++;
      if (ack !== 3'b000) ack_n++;
      if (clear_done === 1'b1) done_n++;
      if (done_n == 0) begin
        if (clear_busy === 1'b1 && ram_addr == AW'(pulse_at)) clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    req_addr = '0;
    req_data = '0;
    do_reset;
    n_total++;
    if ({ack, ram_wr_en, clear_busy, clear_done} !== 6'b0)
      $display("FAIL reset_ctrl: got ack=%b we=%b busy=%b done=%b, required all 0",
               ack, ram_wr_en, clear_busy, clear_done);
    else n_pass++;
    n_total++;
    if ({ram_addr, ram_data} !== '0)
      $display("FAIL reset_bus: got addr=%0d data=%h, required 0/0", ram_addr, ram_data);
    else n_pass++;
  endtask

  task automatic test_single;
    do_reset;
    set_req(1, 100, 'h41);
    exp_q.push_back(mk(100, 'h41, 3'b010));
    tick;
    n_total++;
    if (ram_wr_en !== 1'b1 || ack !== 3'b010)
      $display("FAIL single_grant: got we=%b ack=%b, required we=1 ack=010", ram_wr_en, ack);
    else n_pass++;
    tick;
    req = 3'b000;
    n_total++;
    if (ram_wr_en !== 1'b0 || ack !== 3'b000)
      $display("FAIL single_nodouble: got we=%b ack=%b, required we=0 ack=000", ram_wr_en, ack);
    else n_pass++;
    tick;
    tick;
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [2:0] x;
    do_reset;
    set_req(0, 10, 'h11);
    set_req(1, 20, 'h22);
    set_req(2, 30, 'h33);
    exp_q.push_back(mk(10, 'h11, 3'b001));
    exp_q.push_back(mk(20, 'h22, 3'b010));
    exp_q.push_back(mk(30, 'h33, 3'b100));
    for (int k = 0; k < 3; k++) begin
      tick;
      x = 3'b001 << k;
      n_total++;
      if (ram_wr_en !== 1'b1 || ack !== x)
        $display("FAIL rr_grant%0d: got we=%b ack=%b, required we=1 ack=%b", k, ram_wr_en, ack, x);
      else n_pass++;
      req = req & ~x;
    end
    tick;
    n_total++;
    if (ram_wr_en !== 1'b0 || exp_q.size() != 0)
      $display("FAIL rr_end: got we=%b pending=%0d, required 0/0", ram_wr_en, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_fairness;
    int n0;
    int n2;
    logic [2:0] x;
    n0 = 0;
    n2 = 0;
    do_reset;
    set_req(0, 300, 'h30);
    set_req(2, 400, 'h50);
    exp_q.push_back(mk(300, 'h30, 3'b001));
    exp_q.push_back(mk(400, 'h50, 3'b100));
    for (int k = 0; k < 8; k++) begin
      tick;
      x = (k % 2 == 0) ? 3'b001 : 3'b100;
      n_total++;
      if (ram_wr_en !== 1'b1 || ack !== x)
        $display("FAIL fair_grant%0d: got we=%b ack=%b, required we=1 ack=%b", k, ram_wr_en, ack, x);
      else n_pass++;
      if (k < 6) begin
        if (x[0]) begin
          n0++;
          set_req(0, 300 + n0, 'h30 + n0);
          exp_q.push_back(mk(300 + n0, 'h30 + n0, 3'b001));
        end else begin
          n2++;
          set_req(2, 400 + n2, 'h50 + n2);
          exp_q.push_back(mk(400 + n2, 'h50 + n2, 3'b100));
        end
      end else begin
        req = req & ~x;
      end
    end
    tick;
    n_total++;
    if (ram_wr_en !== 1'b0 || exp_q.size() != 0)
      $display("FAIL fair_end: got we=%b pending=%0d, required 0/0", ram_wr_en, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_clear;
    int b;
    int d;
    int a;
    do_reset;
    set_req(0, 77, 'h55);
    clear_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(i, CC, 3'b000));
    exp_q.push_back(mk(77, 'h55, 3'b001));
    tick;
    clear_start = 1'b0;
    run_clear(-1, b, d, a);
    n_total++;
    if (d != 1 || clear_busy !== 1'b0 || ram_wr_en !== 1'b0)
      $display("FAIL clr_done: got done=%0d busy=%b we=%b, required 1/0/0", d, clear_busy, ram_wr_en);
    else n_pass++;
    n_total++;
    if (b != DEPTH || a != 0)
      $display("FAIL clr_busy: got busy=%0d acks=%0d, required %0d/0", b, a, DEPTH);
    else n_pass++;
    tick;
    req = 3'b000;
    n_total++;
    if (ack !== 3'b001 || ram_wr_en !== 1'b1 || clear_done !== 1'b0)
      $display("FAIL clr_ack0: got ack=%b we=%b done=%b, required 001/1/0", ack, ram_wr_en, clear_done);
    else n_pass++;
    tick;
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL clr_drain: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear;
    int b;
    int d;
    int a;
    int extra;
    do_reset;
    clear_start = 1'b1;
    for (int i = 0; i <= 2000; i++) exp_q.push_back(mk(i, CC, 3'b000));
    tick;
    clear_start = 1'b0;
    for (int c = 0; c < 3000 && ram_addr !== AW'(2000); c++) tick;
    n_total++;
    if (ram_addr !== AW'(2000))
      $display("FAIL rmc_reach: got addr=%0d, required 2000", ram_addr);
    else n_pass++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_total++;
    if ({ack, ram_wr_en, clear_busy, clear_done, ram_addr, ram_data} !== '0)
      $display("FAIL rmc_zero: got ack=%b we=%b busy=%b done=%b addr=%0d data=%h, required all 0",
               ack, ram_wr_en, clear_busy, clear_done, ram_addr, ram_data);
    else n_pass++;
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (clear_done === 1'b1 || ram_wr_en === 1'b1) extra++;
      tick;
    end
    n_total++;
    if (extra != 0 || exp_q.size() != 0)
      $display("FAIL rmc_abort: got activity=%0d pending=%0d, required 0/0", extra, exp_q.size());
    else n_pass++;
    clear_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(i, CC, 3'b000));
    tick;
    clear_start = 1'b0;
    n_total++;
    if (ram_addr !== '0 || clear_busy !== 1'b1)
      $display("FAIL rmc_restart: got addr=%0d busy=%b, required 0/1", ram_addr, clear_busy);
    else n_pass++;
    run_clear(-1, b, d, a);
    n_total++;
    if (d != 1 || b != DEPTH || exp_q.size() != 0)
      $display("FAIL rmc_full: got done=%0d busy=%0d pending=%0d, required 1/%0d/0",
               d, b, exp_q.size(), DEPTH);
    else n_pass++;
  endtask

  task automatic test_ignore_clear;
    int b;
    int d;
    int a;
    int extra;
    do_reset;
    clear_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(i, CC, 3'b000));
    tick;
    clear_start = 1'b0;
    run_clear(10, b, d, a);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (clear_done === 1'b1 || ram_wr_en === 1'b1 || clear_busy === 1'b1) extra++;
    end
    n_total++;
    if (d != 1 || extra != 0)
      $display("FAIL ign_done: got done=%0d extra=%0d, required 1/0", d, extra);
    else n_pass++;
    n_total++;
    if (b != DEPTH || exp_q.size() != 0)
      $display("FAIL ign_len: got busy=%0d pending=%0d, required %0d/0", b, exp_q.size(), DEPTH);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    clear_start = 1'b0;
    req = 3'b000;
    test_reset;
    test_single;
    test_round_robin;
    test_fairness;
    test_clear;
    test_reset_mid_clear;
    test_ignore_clear;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
